// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline stall/flush control with destination tracker and stall-run monitor
module stall_ctrl #(
  parameter int CNT_W     = 8,
  parameter int MAX_STALL = 3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             stall,
  input  logic [4:0]       ID_wraddr,
  input  logic             ID_wr_en,
  input  logic             flush,
  output logic             PC_en,
  output logic             IFID_en,
  output logic             IFID_flush,
  output logic [4:0]       EXE_wraddr,
  output logic [4:0]       MEM_wraddr,
  output logic [4:0]       WB_wraddr,
  output logic             EXE_wr_en,
  output logic             MEM_wr_en,
  output logic             WB_wr_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             hz_err
);

  localparam int                RUN_W   = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0]  RUN_SAT = RUN_W'(MAX_STALL + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MAX_STALL);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_nxt;
  logic             hz_set;
  logic             exe_in_en;
  logic [4:0]       exe_in_addr;

  // Stall wins over flush: the held IF/ID entry must survive the stall.
  assign PC_en      = ~stall;
  assign IFID_en    = ~stall;
  assign IFID_flush = flush & ~stall;

  // Writes to $0 are architecturally void, so they enter the tracker as bubbles.
  assign exe_in_en   = ~stall & ID_wr_en & (|ID_wraddr);
  assign exe_in_addr = exe_in_en ? ID_wraddr : 5'd0;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= RUN;
      run_cnt <= '0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    case (state)
      RUN: begin
        if (stall) begin
          state_nxt = STALL;
          run_nxt   = RUN_W'(1);
        end
      end
      STALL: begin
        if (stall) begin
          if (run_cnt != RUN_SAT) run_nxt = run_cnt + RUN_W'(1);
        end else begin
          state_nxt = RUN;
          run_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RUN;
        run_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    hz_set = 1'b0;
    if (stall && (run_nxt > RUN_MAX)) hz_set = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      hz_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (hz_set) hz_err <= 1'b1;
      if (stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      EXE_wraddr <= 5'd0;
      EXE_wr_en  <= 1'b0;
      MEM_wraddr <= 5'd0;
      MEM_wr_en  <= 1'b0;
      WB_wraddr  <= 5'd0;
      WB_wr_en   <= 1'b0;
    end else begin
      EXE_wraddr <= exe_in_addr;
      EXE_wr_en  <= exe_in_en;
      MEM_wraddr <= EXE_wraddr;
      MEM_wr_en  <= EXE_wr_en;
      WB_wraddr  <= MEM_wraddr;
      WB_wr_en   <= MEM_wr_en;
    end
  end

endmodule
